// File: rtl/sequence_pkg.sv
// sequence_pkg: state encoding and default sizing shared by sequence_generator
// and the sequence detector family.
package sequence_pkg;

  localparam int MAX_LEN_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } seq_state_e;

endpackage

// File: rtl/seq_piso.sv
// seq_piso: loadable MSB-first parallel-in/serial-out register.
// On load, the pattern is left-justified so that bit len-1 sits in the top
// position; each shift moves the next bit up. cnt counts remaining bits and
// last flags the final one.
module seq_piso #(
  parameter int MAX_LEN = sequence_pkg::MAX_LEN_DEFAULT,
  parameter int LEN_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [MAX_LEN-1:0] load_data,
  input  logic [LEN_W-1:0]   load_len,
  input  logic               shift,
  output logic               bit_out,
  output logic               last
);

  logic [MAX_LEN-1:0] data_q, data_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [LEN_W-1:0]   shift_amt;

  assign shift_amt = LEN_W'(MAX_LEN) - load_len;
  assign bit_out   = data_q[MAX_LEN-1];
  assign last      = (cnt_q == LEN_W'(1));

  // Load takes priority over shift so a repeated frame can restart in the
  // same cycle its predecessor emits its last bit.
  always_comb begin
    data_d = data_q;
    cnt_d  = cnt_q;
    if (load) begin
      data_d = load_data << shift_amt;
      cnt_d  = load_len;
    end else if (shift && (cnt_q != '0)) begin
      data_d = data_q << 1;
      cnt_d  = cnt_q - LEN_W'(1);
    end
  end

  // Shift register and remaining-bit counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/sequence_generator.sv
// sequence_generator: serial pattern transmitter, MSB-first, one bit per clock,
// with optional gapless repeat and a done pulse on each frame's final bit.
// Optional feature: define SEQ_GEN_PARITY_EN to append an even-parity bit
// to every frame (done then coincides with the parity bit).
module sequence_generator
  import sequence_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEFAULT,
  parameter int LEN_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  input  logic               repeat_en,
  output logic               out,
  output logic               out_valid,
  output logic               busy,
  output logic               done
);

  seq_state_e         state_q, state_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               out_q, out_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               load;
  logic [MAX_LEN-1:0] load_data;
  logic [LEN_W-1:0]   load_len;
  logic               shift;
  logic               piso_bit;
  logic               piso_last;
  logic [LEN_W-1:0]   len_clamped;

  assign len_clamped = (len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len;

  seq_piso #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_piso (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_data (load_data),
    .load_len  (load_len),
    .shift     (shift),
    .bit_out   (piso_bit),
    .last      (piso_last)
  );

`ifdef SEQ_GEN_PARITY_EN
  logic parity_bit;

  // Even parity over the captured len data bits only.
  always_comb begin
    parity_bit = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (LEN_W'(i) < len_q) parity_bit = parity_bit ^ pat_q[i];
    end
  end
`endif

  // Next-state and next-output logic; outputs lag the FSM by one register stage.
  always_comb begin
    state_d     = state_q;
    pat_d       = pat_q;
    len_d       = len_q;
    out_d       = 1'b0;
    out_valid_d = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    load        = 1'b0;
    load_data   = pattern;
    load_len    = len_clamped;
    shift       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && (len != '0)) begin
          pat_d   = pattern;
          len_d   = len_clamped;
          load    = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        out_d       = piso_bit;
        out_valid_d = 1'b1;
        busy_d      = 1'b1;
        shift       = 1'b1;
        if (piso_last) begin
`ifdef SEQ_GEN_PARITY_EN
          state_d = ST_PARITY;
`else
          done_d = 1'b1;
          if (repeat_en) begin
            load      = 1'b1;
            load_data = pat_q;
            load_len  = len_q;
            state_d   = ST_SHIFT;
          end else begin
            state_d = ST_IDLE;
          end
`endif
        end
      end
`ifdef SEQ_GEN_PARITY_EN
      ST_PARITY: begin
        out_d       = parity_bit;
        out_valid_d = 1'b1;
        busy_d      = 1'b1;
        done_d      = 1'b1;
        if (repeat_en) begin
          load      = 1'b1;
          load_data = pat_q;
          load_len  = len_q;
          state_d   = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // State, captured frame and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pat_q       <= '0;
      len_q       <= '0;
      out_q       <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pat_q       <= pat_d;
      len_q       <= len_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_sequence_generator.sv
// tb_sequence_generator: directed and randomized stimulus for sequence_generator,
// compared each cycle against a frame-level reference model.
// Honours SEQ_GEN_PARITY_EN the same way as the design.
module tb_sequence_generator;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;
`ifdef SEQ_GEN_PARITY_EN
  localparam int PARITY_EN = 1;
`else
  localparam int PARITY_EN = 0;
`endif

  logic               clk;
  logic               rst;
  logic               start;
  logic [MAX_LEN-1:0] pattern;
  logic [LEN_W-1:0]   len;
  logic               repeat_en;
  logic               dut_out;
  logic               out_valid;
  logic               busy;
  logic               done;

  int checks = 0;
  int errors = 0;

  // Reference model: a frame in flight is a list of bits (data MSB-first,
  // then parity if enabled) and an index of the next bit to emit.
  bit                 m_active = 0;
  int                 m_k      = 0;
  int                 m_len    = 0;
  logic [MAX_LEN-1:0] m_pat    = '0;
  logic               e_out, e_valid, e_busy, e_done;

  sequence_generator #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .pattern   (pattern),
    .len       (len),
    .repeat_en (repeat_en),
    .out       (dut_out),
    .out_valid (out_valid),
    .busy      (busy),
    .done      (done)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic modelEdge();
    int  flen;
    logic b;
    e_out = 1'b0; e_valid = 1'b0; e_busy = 1'b0; e_done = 1'b0;
    if (rst) begin
      m_active = 0;
    end else if (!m_active) begin
      if (start && (len != 0)) begin
        m_active = 1;
        m_pat    = pattern;
        m_len    = (int'(len) > MAX_LEN) ? MAX_LEN : int'(len);
        m_k      = 0;
      end
    end else begin
      flen = m_len + PARITY_EN;
      if (m_k < m_len) begin
        b = m_pat[m_len - 1 - m_k];
      end else begin
        b = 1'b0;
        for (int i = 0; i < m_len; i++) b = b ^ m_pat[i];
      end
      e_out   = b;
      e_valid = 1'b1;
      e_busy  = 1'b1;
      e_done  = (m_k == flen - 1);
      m_k++;
      if (m_k == flen) begin
        if (repeat_en) m_k = 0;
        else           m_active = 0;
      end
    end
  endtask

  // Compare all four outputs against the model's expectation.
  task automatic checkOutput(input string tag);
    checks++;
    assert (dut_out === e_out) else begin
      errors++;
      $error("FAIL %s out: observed %0b expected %0b", tag, dut_out, e_out);
    end
    checks++;
    assert (out_valid === e_valid) else begin
      errors++;
      $error("FAIL %s out_valid: observed %0b expected %0b", tag, out_valid, e_valid);
    end
    checks++;
    assert (busy === e_busy) else begin
      errors++;
      $error("FAIL %s busy: observed %0b expected %0b", tag, busy, e_busy);
    end
    checks++;
    assert (done === e_done) else begin
      errors++;
      $error("FAIL %s done: observed %0b expected %0b", tag, done, e_done);
    end
  endtask

  // Drive one cycle of inputs, clock it, and check the outputs just after the edge.
  task automatic applyStimulus(input logic r, input logic s, input logic [MAX_LEN-1:0] p,
                               input logic [LEN_W-1:0] l, input logic rep, input string tag);
    rst       = r;
    start     = s;
    pattern   = p;
    len       = l;
    repeat_en = rep;
    @(posedge clk);
    modelEdge();
    #1;
    checkOutput(tag);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; pattern = '0; len = '0; repeat_en = 1'b0;
    $display("[TB] start, parity %0d", PARITY_EN);

    // Reset state
    applyStimulus(1, 0, 8'h00, 4'd0, 0, "reset0");
    applyStimulus(1, 1, 8'hFF, 4'd5, 1, "reset1");

    // Basic len=3 frame "101"
    applyStimulus(0, 1, 8'b0000_0101, 4'd3, 0, "f101_start");
    for (int i = 0; i < 6; i++) applyStimulus(0, 0, 8'h00, 4'd0, 0, "f101_run");

    // len=0 is ignored
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 8'hFF, 4'd0, 0, "len0");

    // len=12 clamps to 8 bits; inputs changed mid-frame are ignored
    applyStimulus(0, 1, 8'hA5, 4'd12, 0, "clamp_start");
    for (int i = 0; i < 10; i++)
      applyStimulus(0, 1'($urandom), 8'($urandom), 4'($urandom), 0, "clamp_midframe");
    applyStimulus(0, 0, 8'h00, 4'd0, 0, "clamp_idle");

    // Gapless repeat of 1101, then release repeat during the third frame
    applyStimulus(0, 1, 8'b0000_1101, 4'd4, 1, "rep_start");
    for (int i = 0; i < 9; i++) applyStimulus(0, 0, 8'h00, 4'd0, 1, "rep_run");
    for (int i = 0; i < 6; i++) applyStimulus(0, 0, 8'h00, 4'd0, 0, "rep_release");

    // Reset mid-frame abandons the frame; a fresh start then works
    applyStimulus(0, 1, 8'hC3, 4'd8, 0, "rst_start");
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 8'h00, 4'd0, 0, "rst_run");
    applyStimulus(1, 0, 8'h00, 4'd0, 0, "rst_mid");
    applyStimulus(0, 0, 8'h00, 4'd0, 0, "rst_after");
    applyStimulus(0, 1, 8'b0000_0100, 4'd3, 0, "rst_fresh");
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 8'h00, 4'd0, 0, "rst_fresh_run");

    // len=1 frames with start held high: minimum one-cycle gap between frames
    for (int i = 0; i < 8; i++) applyStimulus(0, 1, 8'h01, 4'd1, 0, "len1_held");
    applyStimulus(0, 0, 8'h00, 4'd0, 0, "len1_idle");

    // Randomized traffic with occasional reset
    for (int i = 0; i < 400; i++)
      applyStimulus(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) == 0),
                    8'($urandom), 4'($urandom_range(0, 15)),
                    ($urandom_range(0, 2) == 0), "random");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
